// File: rtl/tiny_evg_pkg.sv
// rtl/tiny_evg_pkg.sv - shared tinyEVG event codes and shifter state type
// Purpose: event code constants used as parameter defaults, and the state
//          enum of the seconds event shifter.
// Ports:   none (package).
package tiny_evg_pkg;

    localparam logic [7:0] EVCODE_SHIFT0_DEF = 8'h70;
    localparam logic [7:0] EVCODE_SHIFT1_DEF = 8'h71;
    localparam logic [7:0] EVCODE_LATCH_DEF  = 8'h7D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        GAP   = 2'd2,
        BIT   = 2'd3
    } shifterState_t;

endpackage

// File: rtl/seconds_event_shifter_if.sv
// rtl/seconds_event_shifter_if.sv - event handshake toward the event multiplexer
// Purpose: groups the valid/ack event channel.
// Ports:   eventCode  (master->slave, 8) event to transmit
//          eventValid (master->slave, 1) eventCode is pending
//          eventAck   (slave->master, 1) eventCode accepted this cycle
interface seconds_event_shifter_if;

    logic [7:0] eventCode;
    logic       eventValid;
    logic       eventAck;

    modport master (
        output eventCode,
        output eventValid,
        input  eventAck
    );

    modport slave (
        input  eventCode,
        input  eventValid,
        output eventAck
    );

endinterface

// File: rtl/seconds_event_shifter.sv
// rtl/seconds_event_shifter.sv - serializes next-second value into tinyEVG events
// Purpose: on each PPS strobe emits the seconds-latch event, then shifts out
//          seconds+1 as 32 shift-0/shift-1 events MSB first, with SHIFT_GAP
//          idle cycles after each accepted event.
// Ports:   clk          event clock, rising edge
//          rst          asynchronous active-high reset
//          seconds      current seconds (32), stable in clk domain
//          ppsStrobe    one-cycle second-boundary pulse
//          ev           event channel (master): eventCode/eventValid/eventAck
//          busy         sequence in progress
//          overrunCount saturating count of PPS strobes seen while busy (8)
import tiny_evg_pkg::*;

module seconds_event_shifter #(
    parameter int unsigned SHIFT_GAP     = 100,
    parameter logic [7:0]  EVCODE_SHIFT0 = EVCODE_SHIFT0_DEF,
    parameter logic [7:0]  EVCODE_SHIFT1 = EVCODE_SHIFT1_DEF,
    parameter logic [7:0]  EVCODE_LATCH  = EVCODE_LATCH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    seconds,
    input  logic                           ppsStrobe,
    seconds_event_shifter_if.master        ev,
    output logic                           busy,
    output logic [7:0]                     overrunCount
);

    localparam logic [15:0] GAP_LOAD = 16'(SHIFT_GAP);

    shifterState_t state, stateNext;
    logic [31:0]   shiftReg;
    logic [4:0]    bitIdx;
    logic [15:0]   gapCnt;
    logic          pendingPps;

    logic accept;
    logic restartReq;
    logic loadSeq;
    logic loadGap;
    logic decGap;
    logic decBit;

    assign accept     = ev.eventValid & ev.eventAck;
    // A PPS coinciding with an accept restarts just like one that arrived earlier.
    assign restartReq = pendingPps | ppsStrobe;

    always_comb begin
        stateNext = state;
        loadSeq   = 1'b0;
        loadGap   = 1'b0;
        decGap    = 1'b0;
        decBit    = 1'b0;
        case (state)
            IDLE: begin
                if (ppsStrobe) begin
                    stateNext = LATCH;
                    loadSeq   = 1'b1;
                end
            end
            LATCH: begin
                if (accept) begin
                    if (restartReq) begin
                        stateNext = LATCH;
                        loadSeq   = 1'b1;
                    end else if (SHIFT_GAP == 0) begin
                        stateNext = BIT;
                    end else begin
                        stateNext = GAP;
                        loadGap   = 1'b1;
                    end
                end
            end
            GAP: begin
                // gapCnt is loaded with SHIFT_GAP, so leaving at 1 yields exactly
                // SHIFT_GAP invalid cycles.
                if (pendingPps) begin
                    stateNext = LATCH;
                    loadSeq   = 1'b1;
                end else if (gapCnt <= 16'd1) begin
                    stateNext = BIT;
                end else begin
                    decGap = 1'b1;
                end
            end
            BIT: begin
                if (accept) begin
                    if (restartReq) begin
                        stateNext = LATCH;
                        loadSeq   = 1'b1;
                    end else if (bitIdx == 5'd0) begin
                        stateNext = IDLE;
                    end else begin
                        decBit = 1'b1;
                        if (SHIFT_GAP == 0) begin
                            stateNext = BIT;
                        end else begin
                            stateNext = GAP;
                            loadGap   = 1'b1;
                        end
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ev.eventValid = 1'b0;
        ev.eventCode  = 8'h00;
        case (state)
            LATCH: begin
                ev.eventValid = 1'b1;
                ev.eventCode  = EVCODE_LATCH;
            end
            BIT: begin
                ev.eventValid = 1'b1;
                ev.eventCode  = shiftReg[bitIdx] ? EVCODE_SHIFT1 : EVCODE_SHIFT0;
            end
            default: begin
                ev.eventValid = 1'b0;
                ev.eventCode  = 8'h00;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shiftReg     <= 32'd0;
            bitIdx       <= 5'd0;
            gapCnt       <= 16'd0;
            pendingPps   <= 1'b0;
            overrunCount <= 8'd0;
        end else begin
            state <= stateNext;

            if (loadSeq) begin
                shiftReg <= seconds + 32'd1;
                bitIdx   <= 5'd31;
            end else if (decBit) begin
                bitIdx <= bitIdx - 5'd1;
            end

            if (loadGap) begin
                gapCnt <= GAP_LOAD;
            end else if (decGap) begin
                gapCnt <= gapCnt - 16'd1;
            end

            // A restart consumes any PPS seen so far, including one this cycle.
            if (loadSeq) begin
                pendingPps <= 1'b0;
            end else if (ppsStrobe && busy) begin
                pendingPps <= 1'b1;
            end

            if (ppsStrobe && busy && (overrunCount != 8'hFF)) begin
                overrunCount <= overrunCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seconds_event_shifter.sv
// tb/tb_seconds_event_shifter.sv - scoreboard bench for seconds_event_shifter
module tb_seconds_event_shifter;

    localparam int GAPLEN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seconds;
    logic        ppsStrobe;
    logic        busy;
    logic [7:0]  overrunCount;

    seconds_event_shifter_if ev();

    seconds_event_shifter #(
        .SHIFT_GAP     (GAPLEN),
        .EVCODE_SHIFT0 (8'h70),
        .EVCODE_SHIFT1 (8'h71),
        .EVCODE_LATCH  (8'h7D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seconds      (seconds),
        .ppsStrobe    (ppsStrobe),
        .ev           (ev),
        .busy         (busy),
        .overrunCount (overrunCount)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sbQ[$];
    int         acceptCnt = 0;
    int         gapRun = 0;
    bit         gapArmed = 0;
    bit         gapCheckOn = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pushSeq(input logic [31:0] sec);
        logic [31:0] nxt;
        nxt = sec + 32'd1;
        sbQ.push_back(8'h7D);
        for (int i = 31; i >= 0; i--) sbQ.push_back(nxt[i] ? 8'h71 : 8'h70);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulsePps();
        ppsStrobe = 1'b1;
        tick();
        ppsStrobe = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        if (busy) checkVal({tag, "Timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic waitAccepts(input int target, input string tag);
        int n;
        n = 0;
        while (acceptCnt < target && n < 5000) begin
            tick();
            n++;
        end
        if (acceptCnt < target) checkVal({tag, "Timeout"}, 32'(acceptCnt), 32'(target));
    endtask

    task automatic waitValid(input string tag);
        int n;
        n = 0;
        while (!ev.eventValid && n < 500) begin
            tick();
            n++;
        end
        if (!ev.eventValid) checkVal({tag, "Timeout"}, 32'(ev.eventValid), 32'd1);
    endtask

    // Output monitor: every accepted event is popped from the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            gapArmed = 0;
            gapRun   = 0;
        end else if (ev.eventValid) begin
            if (gapArmed) begin
                checkVal("gapLen", 32'(gapRun), 32'(GAPLEN));
                gapArmed = 0;
            end
            if (ev.eventAck) begin
                if (sbQ.size() == 0) checkVal("sbEmpty", 32'(sbQ.size()), 32'd1);
                else checkVal("code", 32'(ev.eventCode), 32'(sbQ.pop_front()));
                acceptCnt++;
                gapRun   = 0;
                gapArmed = gapCheckOn && (sbQ.size() != 0);
            end
        end else begin
            gapRun++;
        end
    end

    initial begin
        int         n;
        int         base;
        logic [7:0] hold;
        logic [7:0] keep;

        rst = 1'b1;
        seconds = 32'd0;
        ppsStrobe = 1'b0;
        ev.eventAck = 1'b0;
        repeat (3) tick();
        checkVal("rstValid", 32'(ev.eventValid), 32'd0);
        checkVal("rstCode", 32'(ev.eventCode), 32'h00);
        checkVal("rstBusy", 32'(busy), 32'd0);
        checkVal("rstOvr", 32'(overrunCount), 32'd0);
        rst = 1'b0;
        tick();

        // Nominal sequence with ack tied high; gap length and total duration checked.
        gapCheckOn = 1;
        seconds = 32'h12345678;
        ev.eventAck = 1'b1;
        pushSeq(seconds);
        base = acceptCnt;
        ppsStrobe = 1'b1;
        @(posedge clk);
        #1;
        ppsStrobe = 1'b0;
        checkVal("latchValid", 32'(ev.eventValid), 32'd1);
        checkVal("latchCode", 32'(ev.eventCode), 32'h7D);
        checkVal("busyUp", 32'(busy), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 300);
        checkVal("seqCycles", 32'(n), 32'(33 + 32 * GAPLEN));
        checkVal("seqEvents", 32'(acceptCnt - base), 32'd33);
        checkVal("drain1", 32'(sbQ.size()), 32'd0);

        // All-ones seconds wraps to zero.
        seconds = 32'hFFFFFFFF;
        pushSeq(seconds);
        base = acceptCnt;
        pulsePps();
        waitIdle("wrap");
        checkVal("wrapEvents", 32'(acceptCnt - base), 32'd33);
        checkVal("drain2", 32'(sbQ.size()), 32'd0);
        checkVal("ovr0", 32'(overrunCount), 32'd0);

        // PPS in the gap after bit 20 restarts with the newly captured seconds.
        gapCheckOn = 0;
        seconds = 32'hA5A50F0F;
        pushSeq(seconds);
        base = acceptCnt;
        pulsePps();
        waitAccepts(base + 13, "bit20");
        checkVal("inGapValid", 32'(ev.eventValid), 32'd0);
        seconds = 32'h0BADCAFE;
        sbQ.delete();
        pushSeq(seconds);
        pulsePps();
        checkVal("ovr1", 32'(overrunCount), 32'd1);
        waitValid("restart");
        checkVal("restartCode", 32'(ev.eventCode), 32'h7D);

        // Stall a bit event for 10 cycles; a PPS during the stall lets it finish first.
        base = acceptCnt;
        waitAccepts(base + 5, "preStall");
        ev.eventAck = 1'b0;
        waitValid("stall");
        hold = ev.eventCode;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                seconds = 32'h000000FF;
                keep = sbQ[0];
                sbQ.delete();
                sbQ.push_back(keep);
                pushSeq(seconds);
                ppsStrobe = 1'b1;
            end else begin
                ppsStrobe = 1'b0;
            end
            tick();
            checkVal("stallCode", 32'(ev.eventCode), 32'(hold));
            checkVal("stallValid", 32'(ev.eventValid), 32'd1);
        end
        ppsStrobe = 1'b0;
        checkVal("ovr2", 32'(overrunCount), 32'd2);
        ev.eventAck = 1'b1;
        waitIdle("stallDone");
        checkVal("drain3", 32'(sbQ.size()), 32'd0);

        // Reset during BIT aborts everything.
        seconds = 32'h13579BDF;
        pushSeq(seconds);
        base = acceptCnt;
        pulsePps();
        waitAccepts(base + 6, "preRst");
        waitValid("rstBit");
        rst = 1'b1;
        #1;
        checkVal("midRstValid", 32'(ev.eventValid), 32'd0);
        checkVal("midRstBusy", 32'(busy), 32'd0);
        checkVal("midRstOvr", 32'(overrunCount), 32'd0);
        sbQ.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkVal("postRstBusy", 32'(busy), 32'd0);
        seconds = 32'h2468ACE0;
        pushSeq(seconds);
        base = acceptCnt;
        pulsePps();
        waitIdle("clean");
        checkVal("cleanEvents", 32'(acceptCnt - base), 32'd33);
        checkVal("drain4", 32'(sbQ.size()), 32'd0);

        // Overrun counter saturation with the latch event held unacked.
        ev.eventAck = 1'b0;
        seconds = 32'd1;
        pulsePps();
        for (int i = 0; i < 300; i++) begin
            ppsStrobe = 1'b1;
            tick();
            ppsStrobe = 1'b0;
            tick();
            if (i == 99) checkVal("ovr100", 32'(overrunCount), 32'd100);
        end
        checkVal("ovrSat", 32'(overrunCount), 32'd255);
        checkVal("satValid", 32'(ev.eventValid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sbQ.delete();
        tick();
        checkVal("finalOvr", 32'(overrunCount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
